// File: rtl/ats21_cmd_rx.sv
// ATS21 command receiver: captures a two-slot instruction word over two cycles, then
// validates, decodes and issues each slot to the ATS21 core over a valid/ready handshake.
module ats21_cmd_rx #(
  parameter logic [3:0] NONE_CLK_ID = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] ctrlA,
  input  logic [15:0] ctrlB,
  output logic        ready,
  output logic [1:0]  stat,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_src,
  output logic [2:0]  cmd_op,
  output logic [4:0]  cmd_id,
  output logic [3:0]  cmd_clk,
  output logic [1:0]  cmd_flag,
  output logic [15:0] cmd_val,
  output logic [4:0]  mode
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    ISS_A = 3'd3,
    ISS_B = 3'd4
  } state_t;

  // Only the upper-half bits that carry meaning are kept (u[5:4] is reserved).
  typedef struct packed {
    logic [2:0] op;
    logic [4:0] sel;
    logic [1:0] attr;
    logic [3:0] clk_no;
  } upper_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  id;
    logic [3:0]  clk_no;
    logic [1:0]  flag;
    logic [15:0] val;
  } cmd_t;

  typedef struct packed {
    logic issue;
    logic rej;
    logic ill;
    cmd_t cmd;
  } slot_t;

  function automatic slot_t decode(input upper_t u, input logic [15:0] l,
                                   input logic [4:0] m, input logic src);
    slot_t d;
    logic  allow_clk;
    logic  allow_tmr;
    d         = '0;
    allow_clk = m[4] & (src ? m[1] : m[0]);
    allow_tmr = m[4] & (src ? m[3] : m[2]);
    d.cmd.op  = u.op;
    case (u.op)
      3'b001: begin
        d.issue = allow_clk;
        d.cmd.id = {1'b0, u.sel[4:1]};
        d.cmd.flag = u.attr;
        d.cmd.clk_no = NONE_CLK_ID;
      end
      3'b010: begin
        d.issue = allow_clk;
        d.cmd.id = {1'b0, u.sel[4:1]};
        d.cmd.flag = {u.attr[1], 1'b0};
        d.cmd.clk_no = NONE_CLK_ID;
      end
      3'b101: begin
        d.issue = allow_tmr;
        d.cmd.id = u.sel;
        d.cmd.flag = {u.attr[1], 1'b0};
        d.cmd.clk_no = u.clk_no;
        d.cmd.val = l;
      end
      3'b110: begin
        d.issue = allow_tmr;
        d.cmd.id = u.sel;
        d.cmd.flag = 2'b00;
        d.cmd.clk_no = u.clk_no;
        d.cmd.val = l;
      end
      3'b111: begin
        d.issue = allow_tmr;
        d.cmd.id = u.sel;
        d.cmd.flag = {u.attr[1], 1'b0};
        d.cmd.clk_no = NONE_CLK_ID;
      end
      3'b100:  d.ill = 1'b1;
      default: d.issue = 1'b0;
    endcase
    d.rej = (u.op == 3'b001 || u.op == 3'b010 || u.op == 3'b101 ||
             u.op == 3'b110 || u.op == 3'b111) & ~d.issue;
    if (!d.issue) begin
      d.cmd = '0;
    end
    return d;
  endfunction

  state_t      state_r;
  upper_t      upa_r;
  upper_t      upb_r;
  logic [15:0] lob_r;
  logic [4:0]  mode_r;
  logic        ill_r;
  logic        rej_r;
  logic        ready_r;
  logic [1:0]  stat_r;
  logic        cmd_valid_r;
  logic        cmd_src_r;
  cmd_t        cmd_r;

  logic        done_s;
  logic [4:0]  mode_a_s;
  slot_t       dec_a_s;
  slot_t       dec_b_s;

  // Slot B is checked against the mode left behind by slot A of the same transaction.
  assign done_s   = ~cmd_valid_r | cmd_ready;
  assign mode_a_s = (upa_r.op == 3'b011) ? upa_r.sel : mode_r;
  assign dec_a_s  = decode(upa_r, ctrlA, mode_r, 1'b0);
  assign dec_b_s  = decode(upb_r, lob_r, mode_a_s, 1'b1);

  // Transaction sequencer with registered command, status and mode outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      upa_r       <= '0;
      upb_r       <= '0;
      lob_r       <= 16'h0000;
      mode_r      <= 5'b11111;
      ill_r       <= 1'b0;
      rej_r       <= 1'b0;
      ready_r     <= 1'b1;
      stat_r      <= 2'b00;
      cmd_valid_r <= 1'b0;
      cmd_src_r   <= 1'b0;
      cmd_r       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req) begin
            state_r <= HI;
            ready_r <= 1'b0;
          end
        end
        HI: begin
          upa_r   <= {ctrlA[15:6], ctrlA[3:0]};
          upb_r   <= {ctrlB[15:6], ctrlB[3:0]};
          state_r <= LO;
        end
        LO: begin
          lob_r       <= ctrlB;
          ill_r       <= dec_a_s.ill;
          rej_r       <= dec_a_s.rej;
          cmd_valid_r <= dec_a_s.issue;
          cmd_src_r   <= 1'b0;
          cmd_r       <= dec_a_s.cmd;
          state_r     <= ISS_A;
        end
        ISS_A: begin
          if (done_s) begin
            mode_r      <= mode_a_s;
            ill_r       <= ill_r | dec_b_s.ill;
            rej_r       <= rej_r | dec_b_s.rej;
            cmd_valid_r <= dec_b_s.issue;
            cmd_src_r   <= dec_b_s.issue;
            cmd_r       <= dec_b_s.cmd;
            state_r     <= ISS_B;
          end
        end
        ISS_B: begin
          if (done_s) begin
            if (upb_r.op == 3'b011) begin
              mode_r <= upb_r.sel;
            end
            stat_r      <= ill_r ? 2'b10 : (rej_r ? 2'b01 : 2'b00);
            cmd_valid_r <= 1'b0;
            cmd_src_r   <= 1'b0;
            cmd_r       <= '0;
            ready_r     <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          cmd_valid_r <= 1'b0;
          cmd_src_r   <= 1'b0;
          cmd_r       <= '0;
          ready_r     <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign ready     = ready_r;
  assign stat      = stat_r;
  assign mode      = mode_r;
  assign cmd_valid = cmd_valid_r;
  assign cmd_src   = cmd_src_r;
  assign cmd_op    = cmd_r.op;
  assign cmd_id    = cmd_r.id;
  assign cmd_clk   = cmd_r.clk_no;
  assign cmd_flag  = cmd_r.flag;
  assign cmd_val   = cmd_r.val;

endmodule

// File: tb/tb_ats21_cmd_rx.sv
// Self-checking bench for ats21_cmd_rx: a transaction-level model predicts issued commands,
// status and mode; a per-cycle monitor checks the handshake against it.
module tb_ats21_cmd_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        cmd_ready = 1'b1;
  logic [15:0] ctrlA = 16'h0000;
  logic [15:0] ctrlB = 16'h0000;
  logic        ready, cmd_valid, cmd_src;
  logic [1:0]  stat, cmd_flag;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_id, mode;
  logic [3:0]  cmd_clk;
  logic [15:0] cmd_val;

  ats21_cmd_rx dut (
    .clk(clk), .reset(reset), .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB),
    .ready(ready), .stat(stat), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_op(cmd_op), .cmd_id(cmd_id), .cmd_clk(cmd_clk),
    .cmd_flag(cmd_flag), .cmd_val(cmd_val), .mode(mode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        src;
    logic [2:0]  op;
    logic [4:0]  id;
    logic [3:0]  clk_no;
    logic [1:0]  flag;
    logic [15:0] val;
  } cmd_t;

  int   total = 0;
  int   bad = 0;
  cmd_t exp_q[$];
  logic [4:0] m_mode = 5'h1F;
  logic [1:0] m_stat = 2'b00;
  logic mon_en = 1'b0;
  logic prev_stall = 1'b0;
  cmd_t prev_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: what the receiver must issue and report for words a, b.
  task automatic model_txn(input logic [31:0] a, input logic [31:0] b);
    logic ill, rej;
    ill = 1'b0;
    rej = 1'b0;
    for (int s = 0; s < 2; s++) begin
      logic [15:0] u, l;
      logic [2:0]  op;
      logic        ok, is_clk, has_val;
      cmd_t        c;
      u = (s == 0) ? a[31:16] : b[31:16];
      l = (s == 0) ? a[15:0] : b[15:0];
      op = u[15:13];
      is_clk = (op == 3'b001) || (op == 3'b010);
      has_val = (op == 3'b101) || (op == 3'b110);
      if (op == 3'b011) begin
        m_mode = u[12:8];
      end else if (op == 3'b100) begin
        ill = 1'b1;
      end else if (op != 3'b000) begin
        ok = m_mode[4] && (is_clk ? m_mode[s] : m_mode[2 + s]);
        if (!ok) begin
          rej = 1'b1;
        end else begin
          c.src = (s == 1);
          c.op = op;
          c.id = is_clk ? {1'b0, u[12:9]} : u[12:8];
          c.flag = (op == 3'b001) ? u[7:6] : ((op == 3'b110) ? 2'b00 : {u[7], 1'b0});
          c.clk_no = has_val ? u[3:0] : 4'hF;
          c.val = has_val ? l : 16'h0000;
          exp_q.push_back(c);
        end
      end
    end
    m_stat = ill ? 2'b10 : (rej ? 2'b01 : 2'b00);
  endtask

  // Per-cycle monitor: zeroed idle fields, stable stalled commands, accepted commands in order.
  always @(negedge clk) begin
    cmd_t cur;
    cur = {cmd_src, cmd_op, cmd_id, cmd_clk, cmd_flag, cmd_val};
    if (mon_en) begin
      if (!cmd_valid) chk("idle_fields_zero", cur, 32'h0);
      if (prev_stall) begin
        chk("stall_valid", cmd_valid, 1);
        chk("stall_hold", cur, prev_c);
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) chk("unexpected_cmd", 1, 0);
        else chk("cmd_fields", cur, exp_q.pop_front());
      end
    end
    prev_stall = mon_en && cmd_valid && !cmd_ready;
    prev_c = cur;
  end

  // Drive req, then the upper halves, then the lower halves; returns with the DUT in LO.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2; req = 1'b1;
    @(posedge clk); #2; req = 1'b0; ctrlA = a[31:16]; ctrlB = b[31:16];
    @(posedge clk); #2; ctrlA = a[15:0]; ctrlB = b[15:0];
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, ready, 1);
  endtask

  task automatic check_end(input string name);
    chk({name, "_stat"}, stat, m_stat);
    chk({name, "_mode"}, mode, m_mode);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic txn(input string name, input logic [31:0] a, input logic [31:0] b);
    model_txn(a, b);
    send(a, b);
    wait_idle(name);
    check_end(name);
  endtask

  initial begin
    #22 reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_stat", stat, 0);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_mode", mode, 5'h1F);
    mon_en = 1'b1;

    // Two clock-slot commands with full timing pinned by hand.
    model_txn(32'h2040_0000, 32'h2200_0000);
    send(32'h2040_0000, 32'h2200_0000);
    @(negedge clk);
    chk("t1_lo_ready", ready, 0);
    chk("t1_lo_valid", cmd_valid, 0);
    @(negedge clk);
    chk("t1_a_valid", cmd_valid, 1);
    chk("t1_a_src", cmd_src, 0);
    chk("t1_a_id", cmd_id, 0);
    chk("t1_a_flag", cmd_flag, 2'b01);
    chk("t1_a_clk", cmd_clk, 4'hF);
    @(negedge clk);
    chk("t1_b_valid", cmd_valid, 1);
    chk("t1_b_src", cmd_src, 1);
    chk("t1_b_id", cmd_id, 1);
    chk("t1_b_flag", cmd_flag, 2'b00);
    @(negedge clk);
    chk("t1_ready", ready, 1);
    chk("t1_stat", stat, 2'b00);
    check_end("t1");

    // Alarm with value, NOP in slot B taking a single ISS cycle.
    model_txn(32'hA583_1234, 32'h0000_0000);
    send(32'hA583_1234, 32'h0000_0000);
    @(negedge clk);
    @(negedge clk);
    chk("t2_valid", cmd_valid, 1);
    chk("t2_id", cmd_id, 5);
    chk("t2_flag", cmd_flag, 2'b10);
    chk("t2_clk", cmd_clk, 3);
    chk("t2_val", cmd_val, 16'h1234);
    @(negedge clk);
    chk("t2_issb_valid", cmd_valid, 0);
    chk("t2_issb_ready", ready, 0);
    @(negedge clk);
    chk("t2_ready", ready, 1);
    check_end("t2");

    // Deactivate, then illegal opcode wins over rejection, then restore.
    txn("t3", 32'h6000_0000, 32'h2200_0000);
    chk("t3_mode_lit", mode, 5'b00000);
    chk("t3_stat_lit", stat, 2'b01);
    txn("t4", 32'h8000_0000, 32'h2200_0000);
    chk("t4_stat_lit", stat, 2'b10);
    txn("t5", 32'h7F00_0000, 32'h0000_0000);
    chk("t5_stat_lit", stat, 2'b00);

    // Per-client permissions, with a mode write governing slot B of the same transaction.
    txn("t6", 32'h7900_0000, 32'h2200_0000);
    chk("t6_mode_lit", mode, 5'b11001);
    chk("t6_stat_lit", stat, 2'b01);
    txn("t7", 32'hA583_1234, 32'hC103_BEEF);
    txn("t8", 32'h4280_0000, 32'hE680_0000);

    // Backpressure in ISS_A with a stray req that must be ignored.
    txn("t9", 32'h7F00_0000, 32'h0000_0000);
    cmd_ready = 1'b0;
    model_txn(32'h2040_0000, 32'h2200_0000);
    send(32'h2040_0000, 32'h2200_0000);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      req = (i == 1);
      @(negedge clk);
      chk("t10_stall_valid", cmd_valid, 1);
      chk("t10_stall_id", cmd_id, 0);
      chk("t10_stall_src", cmd_src, 0);
      chk("t10_stall_ready", ready, 0);
    end
    @(posedge clk); #2;
    req = 1'b0;
    cmd_ready = 1'b1;
    wait_idle("t10");
    check_end("t10");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t10_no_retrigger", ready, 1);
    end

    // Reset during LO aborts without issuing anything.
    txn("t11", 32'h7900_0000, 32'h0000_0000);
    send(32'h2040_0000, 32'h2200_0000);
    #1 reset = 1'b0;
    #3 reset = 1'b1;
    m_mode = 5'h1F;
    exp_q.delete();
    chk("t12_ready", ready, 1);
    chk("t12_valid", cmd_valid, 0);
    chk("t12_mode", mode, 5'b11111);
    chk("t12_stat", stat, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t12_quiet", cmd_valid, 0);
    end
    txn("t13", 32'h2040_0000, 32'h2200_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
